// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared FSM encoding, masks and mode constants for the memory copy master
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD     = 2'd1,
    ST_WR     = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] WMASK_FULL = 4'b1111;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  // Byte enables for the final partial word; a zero remainder means a full word.
  function automatic logic [3:0] tail_mask(input logic [1:0] rem);
    case (rem)
      2'd1:    tail_mask = 4'b0001;
      2'd2:    tail_mask = 4'b0011;
      2'd3:    tail_mask = 4'b0111;
      default: tail_mask = WMASK_FULL;
    endcase
  endfunction

endpackage

// File: rtl/mem_copy_master.sv
// rtl/mem_copy_master.sv - single-command block copy / fill bus initiator
module mem_copy_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len_bytes,
  input  logic [31:0]           fill_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata
);
  import mem_bus_pkg::*;

  state_t                state_q, state_n;
  logic                  mode_q, mode_n;
  logic [ADDR_WIDTH-1:0] src_q, src_n;
  logic [ADDR_WIDTH-1:0] dst_q, dst_n;
  logic [LEN_WIDTH-1:0]  rem_q, rem_n;
  logic [31:0]           fill_q, fill_n;
  logic                  rej_q, rej_n;

  logic                  busy_d, done_d, err_d, rstrb_d, copy_wr_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [3:0]            wmask_d;
  logic [31:0]           wdata_d;
  logic                  copy_wr_q;
  logic [31:0]           wdata_q;

  // State, command context and registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      fill_q    <= '0;
      rej_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_rstrb <= 1'b0;
      mem_wmask <= '0;
      wdata_q   <= '0;
      copy_wr_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      mode_q    <= mode_n;
      src_q     <= src_n;
      dst_q     <= dst_n;
      rem_q     <= rem_n;
      fill_q    <= fill_n;
      rej_q     <= rej_n;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      mem_addr  <= addr_d;
      mem_rstrb <= rstrb_d;
      mem_wmask <= wmask_d;
      wdata_q   <= wdata_d;
      copy_wr_q <= copy_wr_d;
    end
  end

  // Next state plus next command context (addresses advance and remainder shrinks on each write).
  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    src_n   = src_q;
    dst_n   = dst_q;
    rem_n   = rem_q;
    fill_n  = fill_q;
    rej_n   = rej_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_n = mode;
          src_n  = src_addr;
          dst_n  = dst_addr;
          rem_n  = len_bytes;
          fill_n = fill_data;
          rej_n  = (dst_addr[1:0] != 2'b00) ||
                   ((mode == MODE_COPY) && (src_addr[1:0] != 2'b00));
          if (rej_n || (len_bytes == '0)) state_n = ST_FINISH;
          else if (mode == MODE_COPY)     state_n = ST_RD;
          else                            state_n = ST_WR;
        end
      end
      ST_RD: state_n = ST_WR;
      ST_WR: begin
        src_n = src_q + ADDR_WIDTH'(4);
        dst_n = dst_q + ADDR_WIDTH'(4);
        rem_n = (rem_q >= LEN_WIDTH'(4)) ? rem_q - LEN_WIDTH'(4) : '0;
        if (rem_n == '0)                state_n = ST_FINISH;
        else if (mode_q == MODE_COPY)   state_n = ST_RD;
        else                            state_n = ST_WR;
      end
      default: begin
        state_n = ST_IDLE;
        rej_n   = 1'b0;
      end
    endcase
  end

  // Bus outputs for the upcoming state, so every output leaves a flop.
  always_comb begin
    busy_d    = (state_n == ST_RD) || (state_n == ST_WR);
    done_d    = (state_n == ST_FINISH);
    err_d     = (state_n == ST_FINISH) && rej_n;
    rstrb_d   = (state_n == ST_RD);
    addr_d    = '0;
    wmask_d   = '0;
    wdata_d   = '0;
    copy_wr_d = (state_n == ST_WR) && (mode_n == MODE_COPY);
    if (state_n == ST_RD) begin
      addr_d = src_n;
    end else if (state_n == ST_WR) begin
      addr_d  = dst_n;
      wmask_d = (rem_n >= LEN_WIDTH'(4)) ? WMASK_FULL : tail_mask(rem_n[1:0]);
      if (mode_n == MODE_FILL) wdata_d = fill_n;
    end
  end

  // Copy writes forward the word the RAM returned for the preceding read.
  assign mem_wdata = copy_wr_q ? mem_rdata : wdata_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// tb/tb_mem_copy_master.sv - scoreboard bench for mem_copy_master with a behavioural word RAM
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_bytes = '0;
  logic [31:0] fill_data = '0;
  logic        busy, done, err, mem_rstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;

  logic        tb_we = 1'b0;
  logic [7:0]  tb_widx = '0;
  logic [31:0] tb_wdata = '0;
  logic [31:0] ram [0:255] = '{default: 32'h0};
  logic [31:0] exp_mem [0:255] = '{default: 32'h0};

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0, bc = 0, rc = 0, wc = 0, dc = 0;
  int last_wr = 0, done_cyc = 0;
  logic last_err = 1'b0;

  mem_copy_master #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_bytes(len_bytes), .fill_data(fill_data),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word RAM: byte-masked writes, read data one cycle after the strobe and held.
  always @(posedge clk) begin
    if (tb_we) ram[tb_widx] <= tb_wdata;
    else begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_rstrb) mem_rdata <= ram[mem_addr[9:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_mask(input int r);
    if (r >= 4) return 4'hF;
    return 4'((1 << r) - 1);
  endfunction

  // One cycle of monitoring at the falling edge; writes are matched against the scoreboard.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (busy) bc++;
      if (mem_rstrb) rc++;
      if (mem_rstrb && (mem_wmask != 4'h0)) check("rstrb_wmask_excl", 32'(mem_wmask), 32'h0);
      if (mem_wmask != 4'h0) begin
        wc++;
        last_wr = cyc;
        if (sb.size() == 0) check("unexpected_write", mem_addr, 32'hFFFFFFFF);
        else begin
          e = sb.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_mask", 32'(mem_wmask), 32'(e.mask));
          check("wr_data", mem_wdata, e.data);
        end
      end
      if (done) begin
        dc++;
        done_cyc = cyc;
        last_err = err;
      end
    end
  endtask

  task automatic run_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                         input int len, input logic [31:0] f, input logic exp_err,
                         input logic poke, input int rst_after);
    int words, nw, b0, r0, w0, d0, t;
    wr_t e;
    words = exp_err ? 0 : (len + 3) / 4;
    nw = (rst_after > 0) ? rst_after : words;
    for (int i = 0; i < nw; i++) begin
      e.addr = d + 32'(4 * i);
      e.mask = exp_mask(len - 4 * i);
      e.data = (m == 1'b1) ? f : exp_mem[(s[9:2] + 8'(i))];
      for (int b = 0; b < 4; b++)
        if (e.mask[b]) exp_mem[e.addr[9:2]][8*b +: 8] = e.data[8*b +: 8];
      sb.push_back(e);
    end
    b0 = bc; r0 = rc; w0 = wc; d0 = dc;
    tick();
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; len_bytes = 16'(len); fill_data = f;
    tick();
    start = 1'b0;
    t = 0;
    while (dc == d0 && t < 300) begin
      if (rst_after > 0 && wc == w0 + rst_after) break;
      if (poke && t == 3) begin
        start = 1'b1; mode = 1'b1; dst_addr = 32'h300; len_bytes = 16'd8; fill_data = 32'h12345678;
      end
      if (poke && t == 4) start = 1'b0;
      tick();
      t++;
    end
    if (rst_after > 0) begin
      reset = 1'b1;
      tick();
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_rstrb", 32'(mem_rstrb), 32'h0);
      check("rst_wmask", 32'(mem_wmask), 32'h0);
      reset = 1'b0;
      repeat (3) tick();
      check("rst_no_done", 32'(dc - d0), 32'h0);
      check("rst_writes", 32'(wc - w0), 32'(rst_after));
    end else begin
      check("done_seen", 32'(dc != d0), 32'h1);
      check("err", 32'(last_err), 32'(exp_err));
      check("busy_cycles", 32'(bc - b0), 32'((m == 1'b1) ? words : 2 * words));
      check("read_count", 32'(rc - r0), 32'((m == 1'b1) ? 0 : words));
      check("write_count", 32'(wc - w0), 32'(words));
      if (words > 0) check("done_latency", 32'(done_cyc - last_wr), 32'h1);
      tick();
    end
    check("sb_empty", 32'(sb.size()), 32'h0);
    sb.delete();
  endtask

  initial begin
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_rstrb", 32'(mem_rstrb), 32'h0);
    check("reset_wmask", 32'(mem_wmask), 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      tb_we = 1'b1; tb_widx = 8'(i); tb_wdata = 32'h11111111 * 32'(i + 1);
      exp_mem[i] = 32'h11111111 * 32'(i + 1);
      tick();
    end
    tb_we = 1'b0;

    run_cmd(1'b1, 32'h0, 32'h100, 16, 32'hDEADBEEF, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) check("fill_ram", ram[64 + i], 32'hDEADBEEF);

    run_cmd(1'b0, 32'h0, 32'h200, 16, 32'h0, 1'b0, 1'b1, 0);
    check("copy_ram0", ram[128], 32'h11111111);
    check("copy_ram1", ram[129], 32'h22222222);
    check("copy_ram2", ram[130], 32'h33333333);
    check("copy_ram3", ram[131], 32'h44444444);
    check("ignored_start", ram[192], 32'h0);

    run_cmd(1'b1, 32'h0, 32'h40, 6, 32'hA5A5A5A5, 1'b0, 1'b0, 0);
    check("tail_full", ram[16], 32'hA5A5A5A5);
    check("tail_part", ram[17], 32'h0000A5A5);
    check("tail_beyond", ram[18], 32'h0);

    run_cmd(1'b1, 32'h0, 32'h180, 0, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    check("len0_ram", ram[96], 32'h0);
    run_cmd(1'b1, 32'h0, 32'h102, 8, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
    check("misaligned_dst_ram", ram[64], 32'hDEADBEEF);
    run_cmd(1'b0, 32'h1, 32'h200, 8, 32'h0, 1'b1, 1'b0, 0);

    run_cmd(1'b0, 32'h0, 32'h280, 16, 32'h0, 1'b0, 1'b0, 2);
    check("rstcopy_w0", ram[160], 32'h11111111);
    check("rstcopy_w1", ram[161], 32'h22222222);
    check("rstcopy_w2", ram[162], 32'h0);
    check("rstcopy_w3", ram[163], 32'h0);

    run_cmd(1'b0, 32'h100, 32'h380, 7, 32'h0, 1'b0, 1'b0, 0);
    check("copy_tail_w0", ram[224], 32'hDEADBEEF);
    check("copy_tail_w1", ram[225], 32'h00ADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
